// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment driver: frame shadow, dead band per slot, adjust-mode blink.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000,
   parameter int SEL_W     = $clog2(DIGITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] digits,
   input  logic [DIGITS-1:0]   dp,
   input  logic                adj,
   input  logic [SEL_W-1:0]    sel,
   output logic [DIGITS-1:0]   an,
   output logic [7:0]          seg
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [SEL_W-1:0]   IDX_LAST   = SEL_W'(DIGITS - 1);

   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                phase_q, phase_d;
   logic [4*DIGITS-1:0] dig_sh_q, dig_sh_d;
   logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic                loaded_q, loaded_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;

   logic                scan_wrap;
   logic                frame_end;
   logic                blank;
   logic [3:0]          nib;
   logic                dp_bit;
   logic [6:0]          seg7;
   logic [DIGITS-1:0]   an_sel;

`ifdef SEVSEG_LZ_BLANK_EN
   logic [DIGITS-1:0]   lz_q, lz_d;
   logic                lz_run;
   logic                lz_bit;
`endif

   function automatic logic [6:0] dec7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      scan_wrap  = (scan_cnt_q == SCAN_LAST);
      frame_end  = scan_wrap && (idx_q == IDX_LAST);
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      if (scan_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // Blink timer only runs in adjust mode so the first off phase is a full period after adj rises.
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      if (adj) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            phase_d     = phase_q;
         end
      end

      dig_sh_d = dig_sh_q;
      dp_sh_d  = dp_sh_q;
      loaded_d = loaded_q;
      if (frame_end) begin
         dig_sh_d = digits;
         dp_sh_d  = dp;
         loaded_d = 1'b1;
      end

`ifdef SEVSEG_LZ_BLANK_EN
      lz_d   = lz_q;
      lz_run = 1'b1;
      if (frame_end) begin
         lz_d = '0;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run  = lz_run && (digits[4*i +: 4] == 4'd0);
            lz_d[i] = lz_run;
         end
      end
`endif

      nib    = 4'hF;
      dp_bit = 1'b0;
      an_sel = '1;
`ifdef SEVSEG_LZ_BLANK_EN
      lz_bit = 1'b0;
`endif
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == SEL_W'(i)) begin
            nib       = dig_sh_q[4*i +: 4];
            dp_bit    = dp_sh_q[i];
            an_sel[i] = 1'b0;
`ifdef SEVSEG_LZ_BLANK_EN
            lz_bit    = lz_q[i];
`endif
         end
      end

`ifdef SEVSEG_LZ_BLANK_EN
      seg7 = lz_bit ? 7'b1111111 : dec7(nib);
`else
      seg7 = dec7(nib);
`endif

      // Until the first frame is latched the display stays dark, anodes included.
      blank = (scan_cnt_q == '0) || !loaded_q || (adj && (sel == idx_q) && !phase_q);
      an_d  = blank ? '1 : an_sel;
      seg_d = blank ? 8'hFF : {~dp_bit, seg7};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         dig_sh_q    <= '1;
         dp_sh_q     <= '0;
         loaded_q    <= 1'b0;
         an_q        <= '1;
         seg_q       <= 8'hFF;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         dig_sh_q    <= dig_sh_d;
         dp_sh_q     <= dp_sh_d;
         loaded_q    <= loaded_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

`ifdef SEVSEG_LZ_BLANK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lz_q <= '0;
      end else begin
         lz_q <= lz_d;
      end
   end
`endif

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: 4-digit main instance plus a 3-digit instance for out-of-range sel.
module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic        adj;
   logic [1:0]  sel;
   logic [3:0]  an;
   logic [7:0]  seg;

   logic [11:0] digits3;
   logic [2:0]  dp3;
   logic        adj3;
   logic [1:0]  sel3;
   logic [2:0]  an3;
   logic [7:0]  seg3;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   localparam logic [3:0] AN_T [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                        4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
   localparam logic [7:0] SEG_A [16] = '{8'hFF, 8'h99, 8'h99, 8'h99, 8'hFF, 8'hB0, 8'hB0, 8'hB0,
                                         8'hFF, 8'h24, 8'h24, 8'h24, 8'hFF, 8'hF9, 8'hF9, 8'hF9};
   localparam logic [7:0] SEG_B [16] = '{8'hFF, 8'h80, 8'h80, 8'h80, 8'hFF, 8'hF8, 8'hF8, 8'hF8,
                                         8'hFF, 8'h02, 8'h02, 8'h02, 8'hFF, 8'h92, 8'h92, 8'h92};
   localparam logic [7:0] SEG3 [3] = '{8'hB0, 8'hA4, 8'hF9};

   seven_seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .adj(adj), .sel(sel), .an(an), .seg(seg)
   );

   seven_seg_scan_ctrl #(.DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .digits(digits3), .dp(dp3), .adj(adj3), .sel(sel3), .an(an3), .seg(seg3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%h required=%h cyc=%0d", tag, obs, req, cyc);
      end
   endtask

   initial begin
      int k, k3, i3;
      logic [2:0] e3;
      logic [7:0] s3;

      rst_n   = 1'b0;
      digits  = 16'h1234;
      dp      = 4'b0100;
      adj     = 1'b0;
      sel     = 2'd0;
      digits3 = 12'h123;
      dp3     = 3'b000;
      adj3    = 1'b1;
      sel3    = 2'd3;

      repeat (5) begin
         @(posedge clk);
         #1;
         chk("rst_an", {4'h0, an}, 8'h0F);
         chk("rst_seg", seg, 8'hFF);
      end
      rst_n = 1'b1;
      cyc   = 0;

      // Blank until the first shadow load at edge 16; edge 17 is digit 0's dead cycle.
      while (cyc < 17) begin
         tick();
         chk("preload_an", {4'h0, an}, 8'h0F);
         chk("preload_seg", seg, 8'hFF);
      end

      while (cyc < 64) begin
         tick();
         k = (cyc - 1) % 16;
         chk("scan_an", {4'h0, an}, {4'h0, AN_T[k]});
         chk("scan_seg", seg, SEG_A[k]);
      end

      while (cyc < 80) begin
         tick();
         k = (cyc - 1) % 16;
         chk("coh_old_an", {4'h0, an}, {4'h0, AN_T[k]});
         chk("coh_old_seg", seg, SEG_A[k]);
         if (cyc == 69) digits = 16'h5678;
      end
      while (cyc < 96) begin
         tick();
         k = (cyc - 1) % 16;
         chk("coh_new_an", {4'h0, an}, {4'h0, AN_T[k]});
         chk("coh_new_seg", seg, SEG_B[k]);
      end

      adj = 1'b1;
      sel = 2'd2;
      while (cyc < 192) begin
         tick();
         k = (cyc - 1) % 16;
         if (cyc >= 129 && cyc <= 160 && k >= 9 && k <= 11) begin
            chk("blink_off_an", {4'h0, an}, 8'h0F);
            chk("blink_off_seg", seg, 8'hFF);
         end else begin
            chk("blink_on_an", {4'h0, an}, {4'h0, AN_T[k]});
            chk("blink_on_seg", seg, SEG_B[k]);
         end
         k3 = (cyc - 1) % 4;
         i3 = ((cyc - 1) / 4) % 3;
         e3 = 3'b111;
         s3 = 8'hFF;
         if (k3 != 0) begin
            e3 = ~(3'b001 << i3);
            s3 = SEG3[i3];
         end
         chk("sel_oor_an", {5'h0, an3}, {5'h0, e3});
         chk("sel_oor_seg", seg3, s3);
      end

      while (cyc < 202) tick();
      chk("adj_offphase_an", {4'h0, an}, 8'h0F);
      adj = 1'b0;
      tick();
      chk("adj_drop_an", {4'h0, an}, 8'h0B);
      chk("adj_drop_seg", seg, 8'h02);

      digits = 16'h1A34;
      dp     = 4'b0000;
      while (cyc < 224) begin
         tick();
         case (cyc)
            210:           chk("inv_d0_seg", seg, 8'h99);
            214:           chk("inv_d1_seg", seg, 8'hB0);
            218, 219, 220: chk("inv_d2_seg", seg, 8'hFF);
            222:           chk("inv_d3_seg", seg, 8'hF9);
            default: ;
         endcase
      end

      digits = 16'h0005;
      while (cyc < 256) begin
         tick();
         case (cyc)
            242: chk("lz5_d0_seg", seg, 8'h92);
`ifdef SEVSEG_LZ_BLANK_EN
            246, 250, 254: chk("lz5_upper_seg", seg, 8'hFF);
`else
            246, 250, 254: chk("z5_upper_seg", seg, 8'hC0);
`endif
            default: ;
         endcase
         if (cyc == 254) digits = 16'h0000;
      end
      while (cyc < 272) begin
         tick();
         case (cyc)
            258: chk("lz0_d0_seg", seg, 8'hC0);
`ifdef SEVSEG_LZ_BLANK_EN
            262, 266, 270: chk("lz0_upper_seg", seg, 8'hFF);
`else
            262, 266, 270: chk("z0_upper_seg", seg, 8'hC0);
`endif
            default: ;
         endcase
      end

      while (cyc < 274) tick();
      chk("pre_rst_an", {4'h0, an}, 8'h0E);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_an", {4'h0, an}, 8'h0F);
      chk("async_rst_seg", seg, 8'hFF);
      chk("async_rst_an3", {5'h0, an3}, 8'h07);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      tick();
      chk("post_rst_an", {4'h0, an}, 8'h0F);
      chk("post_rst_seg", seg, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
